// File: rtl/chess_pkg.sv
// Shared chess definitions: piece codes, colours, opening position and square indexing.
// Imported by the board controller and by the VGA board renderer.
package chess_pkg;

    localparam logic [2:0] PIECE_NONE   = 3'd0;
    localparam logic [2:0] PIECE_PAWN   = 3'd1;
    localparam logic [2:0] PIECE_KNIGHT = 3'd2;
    localparam logic [2:0] PIECE_BISHOP = 3'd3;
    localparam logic [2:0] PIECE_ROOK   = 3'd4;
    localparam logic [2:0] PIECE_QUEEN  = 3'd5;
    localparam logic [2:0] PIECE_KING   = 3'd6;

    localparam logic COLOR_WHITE = 1'b0;
    localparam logic COLOR_BLACK = 1'b1;

    // Square 63 is the leftmost hex digit, square 0 the rightmost.
    localparam logic [255:0] INIT_BOARD = {
        32'h4236_5324,   // row 7: white back rank
        32'h1111_1111,   // row 6: white pawns
        32'h0000_0000,
        32'h0000_0000,
        32'h0000_0000,
        32'h0000_0000,
        32'h9999_9999,   // row 1: black pawns
        32'hCABE_DBAC    // row 0: black back rank
    };

    function automatic logic [5:0] square_index(input logic [2:0] row, input logic [2:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/btn_edge_detect.sv
// Rising-edge detector for one debounced button level; history resets to 1 so a
// button held through reset does not fire on release of reset.
module btn_edge_detect (
    input  logic CLK,
    input  logic RESET,
    input  logic LEVEL,
    output logic RISE
);

    logic prev_reg;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            prev_reg <= 1'b1;
        end else begin
            prev_reg <= LEVEL;
        end
    end

    assign RISE = LEVEL & ~prev_reg;

endmodule

// File: rtl/board_controller.sv
// Chess game-state owner: button events drive cursor, selection and two-cycle
// piece moves on a 64-square board image, with turn order and king-capture end.
module board_controller
    import chess_pkg::*;
#(
    parameter logic [5:0] CURSOR_INIT = 6'd52
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         BTN_UP,
    input  logic         BTN_DOWN,
    input  logic         BTN_LEFT,
    input  logic         BTN_RIGHT,
    input  logic         BTN_CENTER,
    output logic [255:0] BOARD,
    output logic [5:0]   CURSOR_ADDR,
    output logic [5:0]   SELECT_ADDR,
    output logic         SELECT_EN,
    output logic         TURN,
    output logic         GAME_OVER,
    output logic         WINNER
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SELECTED = 3'd1;
    localparam logic [2:0] ST_MOVE     = 3'd2;
    localparam logic [2:0] ST_CLEAR    = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;

    // Bit order doubles as priority: lowest index wins.
    logic [4:0] btn_level;
    logic [4:0] btn_rise;
    logic [4:0] evt;

    assign btn_level = {BTN_RIGHT, BTN_LEFT, BTN_DOWN, BTN_UP, BTN_CENTER};

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_edge
            btn_edge_detect u_edge (
                .CLK   (CLK),
                .RESET (RESET),
                .LEVEL (btn_level[gi]),
                .RISE  (btn_rise[gi])
            );
        end
    endgenerate

    assign evt = btn_rise & (~btn_rise + 5'd1);

    logic [2:0]   state_reg, state_next;
    logic [255:0] board_reg, board_next;
    logic [5:0]   cursor_reg, cursor_next;
    logic [5:0]   select_addr_reg, select_addr_next;
    logic         select_en_reg, select_en_next;
    logic         turn_reg, turn_next;
    logic         game_over_reg, game_over_next;
    logic         winner_reg, winner_next;
    logic [5:0]   src_reg, src_next;
    logic [5:0]   dst_reg, dst_next;
    logic [2:0]   captured_reg, captured_next;

    logic [2:0] cur_row, cur_col;
    logic [3:0] cur_nib, src_nib, moved_nib;
    logic       cur_own;

    assign cur_row = cursor_reg[5:3];
    assign cur_col = cursor_reg[2:0];
    assign cur_nib = board_reg[{cursor_reg, 2'b00} +: 4];
    assign src_nib = board_reg[{src_reg, 2'b00} +: 4];
    assign cur_own = (cur_nib[2:0] != PIECE_NONE) && (cur_nib[3] == turn_reg);

    // Pawns reaching the far rank for their colour become queens.
    always_comb begin
        moved_nib = src_nib;
        if (src_nib[2:0] == PIECE_PAWN &&
            ((src_nib[3] == COLOR_WHITE && dst_reg[5:3] == 3'd0) ||
             (src_nib[3] == COLOR_BLACK && dst_reg[5:3] == 3'd7))) begin
            moved_nib[2:0] = PIECE_QUEEN;
        end
    end

    always_comb begin
        state_next       = state_reg;
        board_next       = board_reg;
        cursor_next      = cursor_reg;
        select_addr_next = select_addr_reg;
        select_en_next   = select_en_reg;
        turn_next        = turn_reg;
        game_over_next   = game_over_reg;
        winner_next      = winner_reg;
        src_next         = src_reg;
        dst_next         = dst_reg;
        captured_next    = captured_reg;

        case (state_reg)
            ST_IDLE, ST_SELECTED: begin
                if (evt[0]) begin
                    if (state_reg == ST_IDLE) begin
                        if (cur_own) begin
                            select_addr_next = cursor_reg;
                            select_en_next   = 1'b1;
                            state_next       = ST_SELECTED;
                        end
                    end else if (cursor_reg == select_addr_reg) begin
                        select_en_next = 1'b0;
                        state_next     = ST_IDLE;
                    end else if (cur_own) begin
                        select_addr_next = cursor_reg;
                    end else begin
                        src_next      = select_addr_reg;
                        dst_next      = cursor_reg;
                        captured_next = cur_nib[2:0];
                        state_next    = ST_MOVE;
                    end
                end else if (evt[1]) begin
                    cursor_next = square_index(cur_row - 3'd1, cur_col);
                end else if (evt[2]) begin
                    cursor_next = square_index(cur_row + 3'd1, cur_col);
                end else if (evt[3]) begin
                    cursor_next = square_index(cur_row, cur_col - 3'd1);
                end else if (evt[4]) begin
                    cursor_next = square_index(cur_row, cur_col + 3'd1);
                end
            end
            ST_MOVE: begin
                board_next[{dst_reg, 2'b00} +: 4] = moved_nib;
                state_next = ST_CLEAR;
            end
            ST_CLEAR: begin
                board_next[{src_reg, 2'b00} +: 4] = 4'h0;
                select_en_next = 1'b0;
                if (captured_reg == PIECE_KING) begin
                    game_over_next = 1'b1;
                    winner_next    = turn_reg;
                    state_next     = ST_DONE;
                end else begin
                    turn_next  = ~turn_reg;
                    state_next = ST_IDLE;
                end
            end
            ST_DONE: begin
                state_next = ST_DONE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_reg       <= ST_IDLE;
            board_reg       <= INIT_BOARD;
            cursor_reg      <= CURSOR_INIT;
            select_addr_reg <= 6'd0;
            select_en_reg   <= 1'b0;
            turn_reg        <= COLOR_WHITE;
            game_over_reg   <= 1'b0;
            winner_reg      <= 1'b0;
            src_reg         <= 6'd0;
            dst_reg         <= 6'd0;
            captured_reg    <= PIECE_NONE;
        end else begin
            state_reg       <= state_next;
            board_reg       <= board_next;
            cursor_reg      <= cursor_next;
            select_addr_reg <= select_addr_next;
            select_en_reg   <= select_en_next;
            turn_reg        <= turn_next;
            game_over_reg   <= game_over_next;
            winner_reg      <= winner_next;
            src_reg         <= src_next;
            dst_reg         <= dst_next;
            captured_reg    <= captured_next;
        end
    end

    assign BOARD       = board_reg;
    assign CURSOR_ADDR = cursor_reg;
    assign SELECT_ADDR = select_addr_reg;
    assign SELECT_EN   = select_en_reg;
    assign TURN        = turn_reg;
    assign GAME_OVER   = game_over_reg;
    assign WINNER      = winner_reg;

endmodule

// File: tb/tb_board_controller.sv
// Randomized and directed bench for board_controller against a square-array game model.
module tb_board_controller;

    logic         CLK = 1'b0;
    logic         RESET = 1'b1;
    logic         BTN_UP = 1'b0, BTN_DOWN = 1'b0, BTN_LEFT = 1'b0, BTN_RIGHT = 1'b0, BTN_CENTER = 1'b0;
    logic [255:0] BOARD;
    logic [5:0]   CURSOR_ADDR, SELECT_ADDR;
    logic         SELECT_EN, TURN, GAME_OVER, WINNER;

    board_controller dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .BTN_UP      (BTN_UP),
        .BTN_DOWN    (BTN_DOWN),
        .BTN_LEFT    (BTN_LEFT),
        .BTN_RIGHT   (BTN_RIGHT),
        .BTN_CENTER  (BTN_CENTER),
        .BOARD       (BOARD),
        .CURSOR_ADDR (CURSOR_ADDR),
        .SELECT_ADDR (SELECT_ADDR),
        .SELECT_EN   (SELECT_EN),
        .TURN        (TURN),
        .GAME_OVER   (GAME_OVER),
        .WINNER      (WINNER)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;
    int n_txn = 0;

    // Model: one int per square (colour*8 + piece), cursor as row/col.
    int mb[64];
    int mrow, mcol, msel, maddr, mturn, mover, mwin;

    // Masks are {CENTER, UP, DOWN, LEFT, RIGHT}.
    localparam logic [4:0] M_C = 5'b10000, M_U = 5'b01000, M_D = 5'b00100, M_L = 5'b00010, M_R = 5'b00001;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        int back[8] = '{4, 2, 3, 5, 6, 3, 2, 4};
        for (int i = 0; i < 64; i++) mb[i] = 0;
        for (int c = 0; c < 8; c++) begin
            mb[c]      = 8 + back[c];
            mb[8 + c]  = 8 + 1;
            mb[48 + c] = 1;
            mb[56 + c] = back[c];
        end
        mrow = 6; mcol = 4; msel = 0; maddr = 0; mturn = 0; mover = 0; mwin = 0;
    endtask

    function automatic logic [255:0] model_vec();
        logic [255:0] v;
        v = '0;
        for (int i = 0; i < 64; i++) v[i*4 +: 4] = mb[i][3:0];
        return v;
    endfunction

    task automatic model_center();
        int idx, p, cap, mv;
        bit own;
        idx = mrow * 8 + mcol;
        p = mb[idx];
        own = (p % 8 != 0) && (p / 8 == mturn);
        if (!msel) begin
            if (own) begin msel = 1; maddr = idx; end
        end else if (idx == maddr) begin
            msel = 0;
        end else if (own) begin
            maddr = idx;
        end else begin
            cap = p % 8;
            mv = mb[maddr];
            if (mv % 8 == 1 && ((mv / 8 == 0 && mrow == 0) || (mv / 8 == 1 && mrow == 7)))
                mv = (mv / 8) * 8 + 5;
            mb[idx] = mv;
            mb[maddr] = 0;
            msel = 0;
            if (cap == 6) begin mover = 1; mwin = mturn; end
            else mturn = 1 - mturn;
        end
    endtask

    task automatic model_apply(input logic [4:0] mask);
        if (mover != 0) return;
        if (mask[4])      model_center();
        else if (mask[3]) mrow = (mrow + 7) % 8;
        else if (mask[2]) mrow = (mrow + 1) % 8;
        else if (mask[1]) mcol = (mcol + 7) % 8;
        else if (mask[0]) mcol = (mcol + 1) % 8;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".board"},  BOARD, model_vec());
        check({tag, ".cursor"}, 256'(CURSOR_ADDR), 256'(mrow * 8 + mcol));
        check({tag, ".sel_en"}, 256'(SELECT_EN), 256'(msel));
        check({tag, ".sel_addr"}, 256'(SELECT_ADDR), 256'(maddr));
        check({tag, ".turn"}, 256'(TURN), 256'(mturn));
        check({tag, ".over"}, 256'(GAME_OVER), 256'(mover));
        check({tag, ".winner"}, 256'(WINNER), 256'(mwin));
    endtask

    task automatic drive(input logic [4:0] mask);
        BTN_CENTER = mask[4]; BTN_UP = mask[3]; BTN_DOWN = mask[2]; BTN_LEFT = mask[1]; BTN_RIGHT = mask[0];
    endtask

    task automatic press(input logic [4:0] mask);
        @(negedge CLK); drive(mask);
        @(negedge CLK); drive(5'b0);
        repeat (3) @(negedge CLK);
        model_apply(mask);
        n_txn++;
        $display("txn %0d mask=%b cursor=%0d sel=%0d/%0d turn=%0d over=%0d", n_txn, mask,
                 CURSOR_ADDR, SELECT_EN, SELECT_ADDR, TURN, GAME_OVER);
        compare_all("press");
    endtask

    task automatic goto(input int target);
        for (int k = 0; k < 8 && mover == 0 && mrow != target / 8; k++) press(M_D);
        for (int k = 0; k < 8 && mover == 0 && mcol != target % 8; k++) press(M_R);
    endtask

    task automatic do_reset();
        @(negedge CLK); RESET = 1'b1; drive(5'b0);
        @(negedge CLK); RESET = 1'b0;
        repeat (2) @(negedge CLK);
        model_reset();
        n_txn++;
        $display("txn %0d reset", n_txn);
        compare_all("reset");
    endtask

    initial begin
        logic [4:0] mask;
        int r;

        // Button held through reset release must not fire.
        model_reset();
        BTN_UP = 1'b1;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        repeat (3) @(negedge CLK);
        compare_all("held_up");
        check("held_up.cursor52", 256'(CURSOR_ADDR), 256'd52);
        check("init.king_sq4", 256'(BOARD[19:16]), 256'hE);
        BTN_UP = 1'b0;
        repeat (2) @(negedge CLK);
        compare_all("held_up_release");

        // Cursor wrap.
        repeat (5) press(M_L);
        check("wrap_left", 256'(CURSOR_ADDR), 256'd55);
        do_reset();
        repeat (7) press(M_U);
        repeat (8) press(M_D);
        check("wrap_updown", 256'(CURSOR_ADDR), 256'd60);

        // Selection rules.
        do_reset();
        press(M_C);
        check("select_en", 256'(SELECT_EN), 256'd1);
        check("select_addr", 256'(SELECT_ADDR), 256'd52);
        press(M_C);
        check("deselect", 256'(SELECT_EN), 256'd0);
        repeat (5) press(M_U);
        press(M_C);
        check("opp_select", 256'(SELECT_EN), 256'd0);

        // e2-e4 with a cycle-level view and a RIGHT pulse during MOVE.
        do_reset();
        press(M_C);
        press(M_U);
        press(M_U);
        @(negedge CLK); drive(M_C);
        @(negedge CLK); drive(M_R);
        @(negedge CLK); drive(5'b0);
        check("move_mid.dst", 256'(BOARD[147:144]), 256'h1);
        check("move_mid.src", 256'(BOARD[211:208]), 256'h1);
        @(negedge CLK);
        check("move_end.dst", 256'(BOARD[147:144]), 256'h1);
        check("move_end.src", 256'(BOARD[211:208]), 256'h0);
        check("move_end.turn", 256'(TURN), 256'd1);
        repeat (2) @(negedge CLK);
        model_apply(M_C);
        compare_all("e2e4");

        // Promotion, then king capture.
        do_reset();
        goto(51); press(M_C);
        goto(3);  press(M_C);
        check("promote", 256'(BOARD[15:12]), 256'h5);
        goto(8);  press(M_C);
        goto(16); press(M_C);
        goto(3);  press(M_C);
        goto(4);  press(M_C);
        check("king.over", 256'(GAME_OVER), 256'd1);
        check("king.winner", 256'(WINNER), 256'd0);
        press(M_U); press(M_C); press(M_L);

        // Priority: CENTER beats UP in the same cycle.
        do_reset();
        press(M_C | M_U);
        check("prio.cursor", 256'(CURSOR_ADDR), 256'd52);
        check("prio.sel", 256'(SELECT_EN), 256'd1);

        // Async reset while in MOVE.
        press(M_U);
        @(negedge CLK); drive(M_C);
        @(posedge CLK);
        #1 drive(5'b0);
        #2 RESET = 1'b1;
        #1;
        model_reset();
        check("async_rst.board", BOARD, model_vec());
        check("async_rst.sel", 256'(SELECT_EN), 256'd0);
        @(negedge CLK);
        check("async_rst.board2", BOARD, model_vec());
        RESET = 1'b0;
        repeat (3) @(negedge CLK);
        compare_all("async_rst");

        // Randomized play.
        for (int t = 0; t < 400; t++) begin
            r = $urandom_range(0, 9);
            if (r < 3)      mask = M_C;
            else if (r < 9) mask = 5'b00001 << $urandom_range(0, 3);
            else            mask = 5'($urandom_range(1, 31));
            press(mask);
            if (mover != 0 && $urandom_range(0, 3) == 0) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
